ccbus_arbiter: RTL

CCBUS_ARBITER -- requirements
Module: ccbus_arbiter

---
 rtl/ccbus_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ccbus_arbiter.sv
// ---------------------------------------------------------------------------
// ccbus_arbiter
//   Grants the shared coherent bus to one of two CPUs, for either a data-class
//   transaction or an instruction fetch.  Data requests normally win over
//   instruction fetches. A saturating starve counter lets a waiting
//   instruction fetch override data after four data grants. Within each class,
//   the CPU that was just served loses priority to the other CPU. Every grant
//   is held until coherence_control pulses done. A one-cycle RELEASE gap
//   follows before the next arbitration.
//
// Ports
//   CLK       in   system clock, rising edge
//   nRST      in   asynchronous active-low reset
//   dreq[1:0] in   per-CPU data-class request
//   ireq[1:0] in   per-CPU instruction-fetch request
//   done      in   one-cycle completion pulse for the granted transaction
//   busy      out  a grant is held
//   gnt_cpu   out  granted CPU index (0 when not busy)
//   gnt_type  out  0 = data grant, 1 = instruction grant (0 when not busy)
//   dgnt[1:0] out  one-hot data grant
//   igrant[1:0] out one-hot instruction grant
//   ccwait[1:0] out snoop-hold to the non-granted CPU during a data grant
// ---------------------------------------------------------------------------
module ccbus_arbiter (
    input  logic       CLK,
    input  logic       nRST,
    input  logic [1:0] dreq,
    input  logic [1:0] ireq,
    input  logic       done,
    output logic       busy,
    output logic       gnt_cpu,
    output logic       gnt_type,
    output logic [1:0] dgnt,
    output logic [1:0] igrant,
    output logic [1:0] ccwait
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DGRANT  = 2'd1,
        IGRANT  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [2:0] STARVE_MAX = 3'd4;

    state_t     state_q,    state_d;
    logic       gnt_cpu_q,  gnt_cpu_d;
    logic       gnt_type_q, gnt_type_d;
    logic       busy_q,     busy_d;
    logic [1:0] dgnt_q,     dgnt_d;
    logic [1:0] igrant_q,   igrant_d;
    logic [1:0] ccwait_q,   ccwait_d;
    logic       dprio_q,    dprio_d;
    logic       iprio_q,    iprio_d;
    logic [2:0] starve_q,   starve_d;

    logic       ovr;
    logic       dwin;
    logic       iwin;

    function automatic logic [1:0] onehot(input logic k);
        return k ? 2'b10 : 2'b01;
    endfunction

    // Winners are chosen from the priority pointer; if the favoured CPU is not
    // requesting, the other one is taken (it must be requesting when used).
    assign ovr  = (starve_q == STARVE_MAX) && (|ireq);
    assign dwin = dreq[dprio_q] ? dprio_q : ~dprio_q;
    assign iwin = ireq[iprio_q] ? iprio_q : ~iprio_q;

    always_comb begin
        state_d    = state_q;
        gnt_cpu_d  = gnt_cpu_q;
        gnt_type_d = gnt_type_q;
        busy_d     = busy_q;
        dgnt_d     = dgnt_q;
        igrant_d   = igrant_q;
        ccwait_d   = ccwait_q;
        dprio_d    = dprio_q;
        iprio_d    = iprio_q;
        starve_d   = starve_q;

        case (state_q)
            IDLE: begin
                if ((|dreq) && !ovr) begin
                    state_d    = DGRANT;
                    gnt_cpu_d  = dwin;
                    gnt_type_d = 1'b0;
                    busy_d     = 1'b1;
                    dgnt_d     = onehot(dwin);
                    ccwait_d   = onehot(~dwin);
                    igrant_d   = 2'b00;
                end else if (|ireq) begin
                    state_d    = IGRANT;
                    gnt_cpu_d  = iwin;
                    gnt_type_d = 1'b1;
                    busy_d     = 1'b1;
                    igrant_d   = onehot(iwin);
                    dgnt_d     = 2'b00;
                    ccwait_d   = 2'b00;
                    starve_d   = 3'd0;
                end
            end
            DGRANT: begin
                if (done) begin
                    state_d = RELEASE;
                    dprio_d = ~gnt_cpu_q;
                    // Only a data grant completed while a fetch waits counts
                    // towards instruction starvation.
                    if ((|ireq) && (starve_q != STARVE_MAX)) begin
                        starve_d = starve_q + 3'd1;
                    end
                    gnt_cpu_d  = 1'b0;
                    gnt_type_d = 1'b0;
                    busy_d     = 1'b0;
                    dgnt_d     = 2'b00;
                    igrant_d   = 2'b00;
                    ccwait_d   = 2'b00;
                end
            end
            IGRANT: begin
                if (done) begin
                    state_d    = RELEASE;
                    iprio_d    = ~gnt_cpu_q;
                    gnt_cpu_d  = 1'b0;
                    gnt_type_d = 1'b0;
                    busy_d     = 1'b0;
                    dgnt_d     = 2'b00;
                    igrant_d   = 2'b00;
                    ccwait_d   = 2'b00;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            gnt_cpu_q  <= 1'b0;
            gnt_type_q <= 1'b0;
            busy_q     <= 1'b0;
            dgnt_q     <= 2'b00;
            igrant_q   <= 2'b00;
            ccwait_q   <= 2'b00;
            dprio_q    <= 1'b0;
            iprio_q    <= 1'b0;
            starve_q   <= 3'd0;
        end else begin
            state_q    <= state_d;
            gnt_cpu_q  <= gnt_cpu_d;
            gnt_type_q <= gnt_type_d;
            busy_q     <= busy_d;
            dgnt_q     <= dgnt_d;
            igrant_q   <= igrant_d;
            ccwait_q   <= ccwait_d;
            dprio_q    <= dprio_d;
            iprio_q    <= iprio_d;
            starve_q   <= starve_d;
        end
    end

    assign busy     = busy_q;
    assign gnt_cpu  = gnt_cpu_q;
    assign gnt_type = gnt_type_q;
    assign dgnt     = dgnt_q;
    assign igrant   = igrant_q;
    assign ccwait   = ccwait_q;

endmodule
